// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receive control path (and reusable by
// the transmit path).
//   rx_ctrl_state_t : receive sequencer states (OFF, HUNT, RUN)
//   FRAME_BITS      : bits per frame (start + 8 data + stop)
//   ERR_CNT_W       : width of the saturating receive-error counter
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HUNT = 2'd1,
    RUN  = 2'd2
  } rx_ctrl_state_t;

  localparam int FRAME_BITS = 10;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small byte FIFO with a registered, first-word fall-through head.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full unless popping the same cycle)
//   i_data     : byte to write
//   i_pop      : remove the head byte (ignored when empty)
//   o_data     : head byte, valid while o_empty = 0; 0 after reset
//   o_full     : occupancy equals Depth
//   o_empty    : occupancy is zero
//   o_count    : exact occupancy, 0..Depth
// Depth must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int Depth = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [7:0]              i_data,
  input  logic                    i_pop,
  output logic [7:0]              o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(Depth):0]  o_count
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

  logic [7:0]      r_mem [Depth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW:0]   r_count;
  logic [7:0]      r_head;

  logic            w_pop;
  logic            w_push;
  logic [PtrW-1:0] w_rd_next;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CountFull);
  assign w_pop     = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push    = i_push && (!o_full || w_pop);
  assign w_rd_next = r_rd_ptr + PtrW'(1);

  // NOTE: the storage array has no reset; only pointers, count and head do,
  // so the array maps onto plain registers or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountOne;
        2'b01:   r_count <= r_count - CountOne;
        default: r_count <= r_count;
      endcase

      // Head register: on a pop it takes the next stored byte, or the incoming
      // byte when the popped entry was the last one; an empty FIFO loads the
      // incoming byte directly.
      if (w_pop) begin
        if (r_count == CountOne) begin
          if (w_push) begin
            r_head <= i_data;
          end
        end else begin
          r_head <= r_mem[w_rd_next];
        end
      end else if (w_push && o_empty) begin
        r_head <= i_data;
      end
    end
  end

  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequencer and byte buffer around the oversampled UART receiver.
//   clk, nReset : clock, asynchronous active-low reset
//   rxEnable    : software receive enable
//   div         : clk cycles per oversample tick minus 1 (used at each reload)
//   rxIn        : synchronised serial line (same signal the receiver sees)
//   rxEn        : oversample strobe to the receiver, only while running
//   rxDone      : receiver byte-complete pulse
//   rxErr       : receiver error pulse
//   rxData      : receiver data register
//   outData     : FIFO head byte (first-word fall-through)
//   outValid    : FIFO not empty
//   outReady    : consumer takes the head byte when outValid is set
//   fifoCount   : FIFO occupancy
//   overrun     : sticky, a byte was dropped on a full FIFO
//   framingErr  : sticky, the receiver reported an error
//   errCount    : saturating count of receiver errors
//   errClear    : clears overrun, framingErr and errCount (a same-cycle set wins)
// The receiver is held off (HUNT) until the line has been high for one whole
// frame of ticks, and goes back to hunting after any receiver error.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int Oversample = 16,
  parameter int DivWidth   = 16,
  parameter int FifoDepth  = 4
) (
  input  logic                        clk,
  input  logic                        nReset,
  input  logic                        rxEnable,
  input  logic [DivWidth-1:0]         div,
  input  logic                        rxIn,
  output logic                        rxEn,
  input  logic                        rxDone,
  input  logic                        rxErr,
  input  logic [7:0]                  rxData,
  output logic [7:0]                  outData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [$clog2(FifoDepth):0]  fifoCount,
  output logic                        overrun,
  output logic                        framingErr,
  output logic [ERR_CNT_W-1:0]        errCount,
  input  logic                        errClear
);

  localparam int HuntW = $clog2(FRAME_BITS * Oversample);
  // Last count value of a full idle frame; the tick that sees it completes it.
  localparam logic [HuntW-1:0]     HuntLast = HuntW'(FRAME_BITS * Oversample - 1);
  localparam logic [ERR_CNT_W-1:0] ErrMax   = '1;

  logic [DivWidth-1:0]  r_div_cnt;
  rx_ctrl_state_t       r_state;
  logic [HuntW-1:0]     r_hunt_cnt;
  logic                 r_pending;
  logic                 r_overrun;
  logic                 r_framing_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_tick;
  rx_ctrl_state_t       w_state_nxt;
  logic [HuntW-1:0]     w_hunt_nxt;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;

  // ---------------------------------------------------------------------------
  // Oversample divider: counts div..0; the zero cycle is the tick and reloads.
  // Holding the counter at div while disabled makes the first tick land div+1
  // cycles after enable, and picks up a new div at every reload.
  // ---------------------------------------------------------------------------
  assign w_tick = rxEnable && (r_div_cnt == '0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_div_cnt <= '0;
    end else if (!rxEnable || (r_div_cnt == '0)) begin
      r_div_cnt <= div;
    end else begin
      r_div_cnt <= r_div_cnt - DivWidth'(1);
    end
  end

  assign rxEn = w_tick && (r_state == RUN);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= OFF;
      r_hunt_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hunt_cnt <= w_hunt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hunt_nxt  = r_hunt_cnt;
    if (!rxEnable) begin
      w_state_nxt = OFF;
      w_hunt_nxt  = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_state_nxt = HUNT;
          w_hunt_nxt  = '0;
        end
        HUNT: begin
          if (w_tick) begin
            if (!rxIn) begin
              w_hunt_nxt = '0;
            end else if (r_hunt_cnt == HuntLast) begin
              w_state_nxt = RUN;
              w_hunt_nxt  = '0;
            end else begin
              w_hunt_nxt = r_hunt_cnt + HuntW'(1);
            end
          end
        end
        RUN: begin
          if (rxErr) begin
            w_state_nxt = HUNT;
            w_hunt_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_hunt_nxt  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte capture: the receiver updates rxData on the same edge that raises
  // rxDone, so the write is delayed one cycle to pick up the new byte.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= rxDone && (r_state == RUN);
    end
  end

  assign w_pop  = outReady && !w_empty;
  assign w_drop = r_pending && w_full && !w_pop;

  uart_rx_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (nReset),
    .i_push  (r_pending),
    .i_data  (rxData),
    .i_pop   (w_pop),
    .o_data  (outData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifoCount)
  );

  assign outValid = !w_empty;

  // ---------------------------------------------------------------------------
  // Sticky flags and error counter; a set event beats errClear in the same
  // cycle, which leaves errCount at 1 rather than 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (errClear) begin
        r_overrun <= 1'b0;
      end

      if (rxErr) begin
        r_framing_err <= 1'b1;
        if (errClear) begin
          r_err_cnt <= ERR_CNT_W'(1);
        end else if (r_err_cnt != ErrMax) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else if (errClear) begin
        r_framing_err <= 1'b0;
        r_err_cnt     <= '0;
      end
    end
  end

  assign overrun    = r_overrun;
  assign framingErr = r_framing_err;
  assign errCount   = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Bench for uart_rx_ctrl. The bench plays the receiver (rxDone/rxErr/rxData)
// and the consumer. A reference model tracks, at frame/byte level, the tick
// phase since enable, the run of consecutive high ticks while hunting, the
// FIFO contents as a queue, and the sticky flags.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int OVS   = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10;

  localparam int M_OFF  = 0;
  localparam int M_HUNT = 1;
  localparam int M_RUN  = 2;

  logic          clk = 1'b0;
  logic          nReset;
  logic          rxEnable;
  logic [DW-1:0] div;
  logic          rxIn;
  logic          rxEn;
  logic          rxDone;
  logic          rxErr;
  logic [7:0]    rxData;
  logic [7:0]    outData;
  logic          outValid;
  logic          outReady;
  logic [2:0]    fifoCount;
  logic          overrun;
  logic          framingErr;
  logic [7:0]    errCount;
  logic          errClear;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_n;      // enabled edges since the last disabled edge
  int         m_mode;   // M_OFF / M_HUNT / M_RUN
  int         m_high;   // consecutive high ticks seen while hunting
  bit         m_pend;   // a completed byte is due to be written next edge
  bit         m_ovr;
  bit         m_fe;
  int         m_ec;
  logic [7:0] m_q[$];
  logic       s_rxen;   // rxEn as sampled in the most recent cycle

  uart_rx_ctrl #(
    .Oversample (OVS),
    .DivWidth   (DW),
    .FifoDepth  (DEPTH)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .rxEnable   (rxEnable),
    .div        (div),
    .rxIn       (rxIn),
    .rxEn       (rxEn),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .rxData     (rxData),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .fifoCount  (fifoCount),
    .overrun    (overrun),
    .framingErr (framingErr),
    .errCount   (errCount),
    .errClear   (errClear)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic bit model_tick();
    return (rxEnable === 1'b1) && ((m_n % (int'(div) + 1)) == int'(div));
  endfunction

  function automatic void model_reset();
    m_n = 0; m_mode = M_OFF; m_high = 0; m_pend = 0;
    m_ovr = 0; m_fe = 0; m_ec = 0;
    m_q.delete();
  endfunction

  function automatic void model_edge(input bit tk);
    bit pop, push, drop;
    pop  = (m_q.size() != 0) && (outReady === 1'b1);
    push = m_pend;
    drop = 0;
    m_pend = (rxDone === 1'b1) && (m_mode == M_RUN);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(rxData);
      else drop = 1;
    end
    if (drop) m_ovr = 1;
    else if (errClear === 1'b1) m_ovr = 0;
    if (rxErr === 1'b1) begin
      m_fe = 1;
      m_ec = (errClear === 1'b1) ? 1 : ((m_ec < 255) ? m_ec + 1 : 255);
    end else if (errClear === 1'b1) begin
      m_fe = 0;
      m_ec = 0;
    end
    if (rxEnable !== 1'b1) begin
      m_n = 0; m_mode = M_OFF; m_high = 0;
    end else begin
      m_n++;
      if (m_mode == M_OFF) begin
        m_mode = M_HUNT; m_high = 0;
      end else if (m_mode == M_HUNT) begin
        if (tk) begin
          m_high = (rxIn === 1'b1) ? m_high + 1 : 0;
          if (m_high == FRAME * OVS) begin
            m_mode = M_RUN; m_high = 0;
          end
        end
      end else if (rxErr === 1'b1) begin
        m_mode = M_HUNT; m_high = 0;
      end
    end
  endfunction

  // One clock cycle: inputs are already driven (after a falling edge); rxEn is
  // compared against the model, then the model follows the rising edge.
  task automatic cycle();
    bit tk;
    bit exp_en;
    #1;
    tk = model_tick();
    exp_en = tk && (m_mode == M_RUN);
    s_rxen = rxEn;
    checks++;
    if (rxEn !== exp_en) begin
      errors++;
      $display("FAIL rxEn t=%0t got %b exp %b", $time, rxEn, exp_en);
    end
    @(posedge clk);
    model_edge(tk);
    @(negedge clk);
  endtask

  task automatic go_run(input int d);
    rxEnable = 0; rxDone = 0; rxErr = 0; errClear = 0; outReady = 0; rxIn = 1;
    div = DW'(d);
    cycle(); cycle();
    rxEnable = 1;
    for (int i = 0; i < 5000; i++) begin
      if (m_mode == M_RUN) break;
      cycle();
    end
  endtask

  // Plays one received frame: line low for a while, then rxDone with the byte.
  task automatic send_byte(input logic [7:0] b, input logic ready_on_push);
    rxIn = 0;
    repeat ($urandom_range(2, 6)) cycle();
    rxIn = 1; rxData = b; rxDone = 1;
    cycle();
    rxDone = 0; outReady = ready_on_push;
    cycle();
    outReady = 0;
    cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    checks++; if (rxEn !== 1'b0)       begin errors++; $display("FAIL reset_rxEn got %b exp 0", rxEn); end
    checks++; if (outData !== 8'h00)   begin errors++; $display("FAIL reset_outData got %h exp 00", outData); end
    checks++; if (outValid !== 1'b0)   begin errors++; $display("FAIL reset_outValid got %b exp 0", outValid); end
    checks++; if (fifoCount !== 3'd0)  begin errors++; $display("FAIL reset_fifoCount got %0d exp 0", fifoCount); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (framingErr !== 1'b0) begin errors++; $display("FAIL reset_framingErr got %b exp 0", framingErr); end
    checks++; if (errCount !== 8'h00)  begin errors++; $display("FAIL reset_errCount got %0d exp 0", errCount); end
    @(negedge clk);
    nReset = 1;
    cycle(); cycle();
  endtask

  task automatic test_hunt_idle();
    int first;
    int pulses;
    rxEnable = 0; rxIn = 1; div = 16'd3;
    cycle(); cycle();
    rxEnable = 1;
    first = -1;
    for (int c = 0; c < 2000; c++) begin
      cycle();
      if (s_rxen === 1'b1) begin
        first = c;
        break;
      end
    end
    // 160 idle ticks of period 4, the first 3 cycles after enable, then one more tick.
    checks++;
    if (first != 3 + 4 * FRAME * OVS) begin
      errors++; $display("FAIL hunt_idle_first_rxEn got %0d exp %0d", first, 3 + 4 * FRAME * OVS);
    end
    pulses = 0;
    repeat (16) begin
      cycle();
      if (s_rxen === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL hunt_idle_pulse_rate got %0d exp 4", pulses);
    end
  endtask

  task automatic test_hunt_glitch();
    int ticks;
    int after;
    bit t;
    rxEnable = 0; rxIn = 1; div = DW'($urandom_range(0, 3));
    cycle(); cycle();
    rxEnable = 1;
    ticks = 0;
    while (ticks < 99) begin
      if (model_tick() && m_mode == M_HUNT) ticks++;
      cycle();
    end
    rxIn = 0;
    do begin
      t = model_tick() && (m_mode == M_HUNT);
      cycle();
    end while (!t);
    rxIn = 1;
    after = -1;
    ticks = 0;
    for (int c = 0; c < 5000; c++) begin
      t = model_tick();
      cycle();
      if (s_rxen === 1'b1) begin
        after = ticks;
        break;
      end
      if (t) ticks++;
    end
    checks++;
    if (after != FRAME * OVS) begin
      errors++; $display("FAIL hunt_glitch_ticks got %0d exp %0d", after, FRAME * OVS);
    end
  endtask

  task automatic test_capture();
    go_run($urandom_range(0, 3));
    send_byte(8'h55, 0);
    send_byte(8'hA3, 0);
    checks++; if (fifoCount !== 3'd2) begin errors++; $display("FAIL capture_count got %0d exp 2", fifoCount); end
    checks++; if (outData !== 8'h55)  begin errors++; $display("FAIL capture_head got %h exp 55", outData); end
    outReady = 1;
    cycle();
    outReady = 0;
    checks++; if (outData !== 8'hA3)  begin errors++; $display("FAIL capture_pop_head got %h exp a3", outData); end
    checks++; if (fifoCount !== 3'd1) begin errors++; $display("FAIL capture_pop_count got %0d exp 1", fifoCount); end
    outReady = 1;
    cycle();
    outReady = 0;
    checks++; if (outValid !== 1'b0)  begin errors++; $display("FAIL capture_drained got %b exp 0", outValid); end
  endtask

  task automatic test_overrun();
    logic [7:0] b [5];
    go_run($urandom_range(0, 3));
    foreach (b[i]) b[i] = 8'($urandom);
    foreach (b[i]) send_byte(b[i], 0);
    checks++; if (fifoCount !== 3'd4) begin errors++; $display("FAIL overrun_count got %0d exp 4", fifoCount); end
    checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL overrun_flag got %b exp 1", overrun); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outData !== b[i]) begin errors++; $display("FAIL overrun_content[%0d] got %h exp %h", i, outData, b[i]); end
      outReady = 1;
      cycle();
      outReady = 0;
    end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL overrun_drained got %b exp 0", outValid); end
    errClear = 1;
    cycle();
    errClear = 0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", overrun); end
    // Fill again; the fifth byte arrives together with a pop.
    foreach (b[i]) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send_byte(b[i], 0);
    send_byte(b[4], 1);
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL overrun_pushpop_flag got %b exp 0", overrun); end
    checks++; if (fifoCount !== 3'd4) begin errors++; $display("FAIL overrun_pushpop_count got %0d exp 4", fifoCount); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (outData !== b[i]) begin errors++; $display("FAIL overrun_pushpop_content[%0d] got %h exp %h", i, outData, b[i]); end
      outReady = 1;
      cycle();
      outReady = 0;
    end
  endtask

  task automatic test_error();
    int d;
    int pulses;
    d = $urandom_range(0, 3);
    go_run(d);
    errClear = 1;
    cycle();
    errClear = 0;
    checks++; if (errCount !== 8'd0) begin errors++; $display("FAIL error_cleared got %0d exp 0", errCount); end
    rxIn = 0; rxErr = 1;
    cycle();
    rxErr = 0;
    checks++; if (framingErr !== 1'b1) begin errors++; $display("FAIL error_framing got %b exp 1", framingErr); end
    checks++; if (errCount !== 8'd1)   begin errors++; $display("FAIL error_count got %0d exp 1", errCount); end
    pulses = 0;
    repeat (3 * (d + 1) + 1) begin
      cycle();
      if (s_rxen === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL error_rxEn_held got %0d pulses exp 0", pulses); end
    rxIn = 1; errClear = 1; rxErr = 1;
    cycle();
    errClear = 0; rxErr = 0;
    checks++; if (framingErr !== 1'b1) begin errors++; $display("FAIL error_clear_race_flag got %b exp 1", framingErr); end
    checks++; if (errCount !== 8'd1)   begin errors++; $display("FAIL error_clear_race_count got %0d exp 1", errCount); end
    // Still hunting, so a byte-complete pulse must be ignored.
    rxData = 8'h5A; rxDone = 1;
    cycle();
    rxDone = 0;
    cycle(); cycle();
    checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL error_done_in_hunt got %0d exp 0", fifoCount); end
    repeat (300) begin
      rxErr = 1;
      cycle();
    end
    rxErr = 0;
    cycle();
    checks++; if (errCount !== 8'd255) begin errors++; $display("FAIL error_saturate got %0d exp 255", errCount); end
  endtask

  task automatic test_disable();
    int d;
    int pulses;
    logic [7:0] b0;
    logic [7:0] b1;
    d = $urandom_range(0, 3);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    go_run(d);
    send_byte(b0, 0);
    send_byte(b1, 0);
    rxIn = 0;
    cycle(); cycle(); cycle();
    rxEnable = 0;
    pulses = 0;
    repeat (2 * (d + 1) + 2) begin
      cycle();
      if (s_rxen === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL disable_rxEn got %0d pulses exp 0", pulses); end
    rxData = 8'hC3; rxDone = 1;
    cycle();
    rxDone = 0;
    cycle(); cycle();
    checks++; if (fifoCount !== 3'd2) begin errors++; $display("FAIL disable_count got %0d exp 2", fifoCount); end
    checks++; if (outData !== b0)     begin errors++; $display("FAIL disable_head got %h exp %h", outData, b0); end
    checks++; if (outValid !== 1'b1)  begin errors++; $display("FAIL disable_valid got %b exp 1", outValid); end
    rxIn = 1; outReady = 1;
    cycle(); cycle();
    outReady = 0;
    checks++; if (outValid !== 1'b0)  begin errors++; $display("FAIL disable_drained got %b exp 0", outValid); end
  endtask

  task automatic test_random();
    go_run(0);
    for (int i = 0; i < 800; i++) begin
      rxDone   = ($urandom_range(0, 7) == 0);
      if (rxDone) rxData = 8'($urandom);
      outReady = $urandom_range(0, 1);
      rxErr    = ($urandom_range(0, 63) == 0);
      errClear = ($urandom_range(0, 31) == 0);
      rxIn     = ($urandom_range(0, 15) != 0);
      rxEnable = ($urandom_range(0, 199) != 0);
      cycle();
      checks++;
      if (fifoCount !== 3'(m_q.size())) begin errors++; $display("FAIL rand_count i=%0d got %0d exp %0d", i, fifoCount, m_q.size()); end
      checks++;
      if (outValid !== (m_q.size() != 0)) begin errors++; $display("FAIL rand_valid i=%0d got %b", i, outValid); end
      if (m_q.size() != 0) begin
        checks++;
        if (outData !== m_q[0]) begin errors++; $display("FAIL rand_head i=%0d got %h exp %h", i, outData, m_q[0]); end
      end
      checks++;
      if (overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun i=%0d got %b exp %b", i, overrun, m_ovr); end
      checks++;
      if (framingErr !== m_fe) begin errors++; $display("FAIL rand_framing i=%0d got %b exp %b", i, framingErr, m_fe); end
      checks++;
      if (errCount !== 8'(m_ec)) begin errors++; $display("FAIL rand_errcount i=%0d got %0d exp %0d", i, errCount, m_ec); end
    end
    rxDone = 0; rxErr = 0; errClear = 0; rxIn = 1; rxEnable = 1; outReady = 1;
    repeat (8) cycle();
    outReady = 0;
  endtask

  task automatic test_reset_midframe();
    rxErr = 1;
    cycle();
    rxErr = 0;
    go_run(1);
    send_byte(8'($urandom), 0);
    rxIn = 0; rxData = 8'h3C; rxDone = 1;
    cycle();
    rxDone = 0;
    #2;
    nReset = 0;
    model_reset();
    #1;
    checks++; if (rxEn !== 1'b0)       begin errors++; $display("FAIL midreset_rxEn got %b exp 0", rxEn); end
    checks++; if (outData !== 8'h00)   begin errors++; $display("FAIL midreset_outData got %h exp 00", outData); end
    checks++; if (outValid !== 1'b0)   begin errors++; $display("FAIL midreset_outValid got %b exp 0", outValid); end
    checks++; if (fifoCount !== 3'd0)  begin errors++; $display("FAIL midreset_fifoCount got %0d exp 0", fifoCount); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL midreset_overrun got %b exp 0", overrun); end
    checks++; if (framingErr !== 1'b0) begin errors++; $display("FAIL midreset_framingErr got %b exp 0", framingErr); end
    checks++; if (errCount !== 8'h00)  begin errors++; $display("FAIL midreset_errCount got %0d exp 0", errCount); end
    @(negedge clk);
    rxEnable = 0; rxIn = 1;
    nReset = 1;
    cycle(); cycle(); cycle();
    checks++; if (fifoCount !== 3'd0) begin errors++; $display("FAIL midreset_no_push got %0d exp 0", fifoCount); end
    checks++; if (outValid !== 1'b0)  begin errors++; $display("FAIL midreset_no_valid got %b exp 0", outValid); end
  endtask

  initial begin
    nReset = 0; rxEnable = 0; div = '0; rxIn = 1; rxDone = 0; rxErr = 0;
    rxData = '0; outReady = 0; errClear = 0; s_rxen = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_hunt_idle();
    test_hunt_glitch();
    test_capture();
    test_overrun();
    test_error();
    test_disable();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
